// File: rtl/hazard_unit_sb.sv
// Hazard unit for the 5-stage F/D/E/M/W pipeline: scalar/vector forwarding, load-use and
// branch control, plus a scoreboard for out-of-band long-latency vector loads.
module hazard_unit_sb #(
   parameter int AW      = 4,
   parameter int NSRC    = 3,
   parameter int MAX_OUT = 4,
   parameter int CW      = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NSRC*AW-1:0]   ra_d,
   input  logic [NSRC-1:0]      src_vec_d,
   input  logic [NSRC-1:0]      src_en_d,
   input  logic [AW-1:0]        wa_d,
   input  logic                 regwrite_d,
   input  logic                 vec_d,
   input  logic                 lvl_d,
   input  logic [NSRC*AW-1:0]   ra_e,
   input  logic [NSRC-1:0]      src_vec_e,
   input  logic [AW-1:0]        wa_e,
   input  logic                 memtoreg_e,
   input  logic                 vec_e,
   input  logic                 lvl_issue_e,
   input  logic [AW-1:0]        wa_m,
   input  logic [AW-1:0]        wa_w,
   input  logic                 regwrite_m,
   input  logic                 regwrite_w,
   input  logic                 vec_m,
   input  logic                 vec_w,
   input  logic                 lvl_done,
   input  logic [AW-1:0]        lvl_done_wa,
   input  logic                 pcsrc_d,
   input  logic                 pcsrc_e,
   input  logic                 pcsrc_m,
   input  logic                 pcsrc_w,
   input  logic                 branch_taken_e,
   output logic [2*NSRC-1:0]    forward_e,
   output logic                 stall_f,
   output logic                 stall_d,
   output logic                 flush_d,
   output logic                 flush_e,
   output logic                 sb_full,
   output logic                 sb_err,
   output logic [CW-1:0]        stall_cycles
);

   localparam int NREG = 1 << AW;
   localparam int OCW  = $clog2(MAX_OUT + 1);

   logic [NREG-1:0] pending_q, pending_d;
   logic [OCW-1:0]  out_cnt_q, out_cnt_d;
   logic [CW-1:0]   stall_cycles_q, stall_cycles_d;
   logic            sb_err_q, sb_err_d;

   logic ld_stall, sb_stall, full_stall, pc_pend, done_ok, cnt_full;

   // Forwarding: the newest producer (M) wins over W; the register file is the fallback.
   always_comb begin
      forward_e = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (regwrite_m && ra_e[i*AW +: AW] == wa_m && src_vec_e[i] == vec_m)
            forward_e[2*i +: 2] = 2'b10;
         else if (regwrite_w && ra_e[i*AW +: AW] == wa_w && src_vec_e[i] == vec_w)
            forward_e[2*i +: 2] = 2'b01;
      end
   end

   always_comb begin
      ld_stall = 1'b0;
      sb_stall = regwrite_d && vec_d && pending_q[wa_d];
      for (int i = 0; i < NSRC; i++) begin
         if (memtoreg_e && src_en_d[i] && ra_d[i*AW +: AW] == wa_e && src_vec_d[i] == vec_e)
            ld_stall = 1'b1;
         if (src_en_d[i] && src_vec_d[i] && pending_q[ra_d[i*AW +: AW]])
            sb_stall = 1'b1;
      end
   end

   assign cnt_full   = (out_cnt_q == OCW'(MAX_OUT));
   assign full_stall = lvl_d && cnt_full;
   assign pc_pend    = pcsrc_d || pcsrc_e || pcsrc_m;

   assign stall_d      = ld_stall || sb_stall || full_stall;
   assign stall_f      = stall_d || pc_pend;
   assign flush_e      = stall_d || branch_taken_e;
   assign flush_d      = pc_pend || pcsrc_w || branch_taken_e;
   assign sb_full      = cnt_full;
   assign sb_err       = sb_err_q;
   assign stall_cycles = stall_cycles_q;

   // Scoreboard next state: a completion only counts against a register that is really pending.
   always_comb begin
      done_ok   = lvl_done && pending_q[lvl_done_wa];
      pending_d = pending_q;
      out_cnt_d = out_cnt_q;
      sb_err_d  = sb_err_q;

      // Clear before set, so an issue and completion to the same register leaves it pending.
      if (done_ok)
         pending_d[lvl_done_wa] = 1'b0;
      if (lvl_issue_e)
         pending_d[wa_e] = 1'b1;

      if (lvl_done && !done_ok)
         sb_err_d = 1'b1;

      if (lvl_issue_e && !done_ok) begin
         if (cnt_full)
            sb_err_d = 1'b1;
         else
            out_cnt_d = out_cnt_q + OCW'(1);
      end else if (!lvl_issue_e && done_ok) begin
         out_cnt_d = out_cnt_q - OCW'(1);
      end

      stall_cycles_d = stall_cycles_q;
      if (stall_d && stall_cycles_q != '1)
         stall_cycles_d = stall_cycles_q + CW'(1);
   end

   // NOTE: pending is a small flop array, not a RAM, so it is reset here with the rest of
   // the state; an asynchronous reset must discard every outstanding load at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q      <= '0;
         out_cnt_q      <= '0;
         stall_cycles_q <= '0;
         sb_err_q       <= 1'b0;
      end else begin
         pending_q      <= pending_d;
         out_cnt_q      <= out_cnt_d;
         stall_cycles_q <= stall_cycles_d;
         sb_err_q       <= sb_err_d;
      end
   end

endmodule
